// File: rtl/rev_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rev_pkg : shared types and sizing helpers for rev_serial_adder       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned C_W = 16;
  localparam int unsigned C_D = 4;
  localparam int unsigned C_N = C_W / C_D;

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned C_CNT_W = cnt_width(C_N);

endpackage
`default_nettype wire

// File: rtl/hng_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hng_gate : 4x4 reversible HNG gate; with d=0, r is sum and s carry   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hng_gate (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic p,
  output logic q,
  output logic r,
  output logic s
);

  assign p = a;
  assign q = b;
  assign r = a ^ b ^ c;
  assign s = ((a ^ b) & c) ^ (a & b) ^ d;

endmodule
`default_nettype wire

// File: rtl/rev_rca_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rev_rca_slice : D-bit combinational ripple chain of HNG gates        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rev_rca_slice #(
  parameter int unsigned D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  logic [D:0]   w_c;
  logic [D-1:0] w_unused_p;
  logic [D-1:0] w_unused_q;

  assign w_c[0] = cin;

  for (genvar i = 0; i < D; i++) begin : g_bit
    hng_gate u_hng (
      .a (a[i]),
      .b (b[i]),
      .c (w_c[i]),
      .d (1'b0),
      .p (w_unused_p[i]),
      .q (w_unused_q[i]),
      .r (sum[i]),
      .s (w_c[i+1])
    );
  end

  assign cout = w_c[D];

endmodule
`default_nettype wire

// File: rtl/rev_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rev_serial_adder : digit-serial reversible adder with accumulator    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rev_serial_adder
  import rev_pkg::*;
#(
  parameter int unsigned W = C_W,
  parameter int unsigned D = C_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         acc_mode,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         acc_ovf
);

  localparam int unsigned N     = W / D;
  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  if ((W % D) != 0 || D > W) begin : g_bad_digit_width
    $error("rev_serial_adder: W must be a multiple of D and D <= W");
  end

  state_t                r_state;
  state_t                w_state_next;
  logic [N-1:0][D-1:0]   r_a;
  logic [N-1:0][D-1:0]   r_b;
  logic [N-1:0][D-1:0]   r_sum;
  logic [N-1:0][D-1:0]   w_sum_next;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_carry;
  logic                  r_cout;
  logic                  r_acc_op;
  logic                  r_acc_ovf;
  logic [W-1:0]          r_acc;
  logic                  w_accept;
  logic                  w_last;
  logic [D-1:0]          w_dsum;
  logic                  w_dcout;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == BUSY) && (r_cnt == C_LAST);

  rev_rca_slice #(.D(D)) u_slice (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .cin  (r_carry),
    .sum  (w_dsum),
    .cout (w_dcout)
  );

  // Full sum including the digit being written this cycle, for acc write-back.
  always_comb begin
    w_sum_next        = r_sum;
    w_sum_next[r_cnt] = w_dsum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = BUSY;
      BUSY:    if (r_cnt == C_LAST) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_acc_op  <= 1'b0;
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else begin
      if ((r_state == IDLE) && acc_clr) begin
        r_acc     <= '0;
        r_acc_ovf <= 1'b0;
      end
      if (w_accept) begin
        r_a      <= a;
        // A coincident clear takes effect first, so the op sees B = 0.
        r_b      <= acc_mode ? (acc_clr ? '0 : r_acc) : b;
        r_carry  <= cin;
        r_cnt    <= '0;
        r_acc_op <= acc_mode;
      end
      if (r_state == BUSY) begin
        r_sum   <= w_sum_next;
        r_carry <= w_dcout;
        r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_last) begin
          r_cout <= w_dcout;
          if (r_acc_op) begin
            r_acc     <= w_sum_next;
            r_acc_ovf <= r_acc_ovf | w_dcout;
          end
        end
      end
    end
  end

  assign sum     = r_sum;
  assign cout    = r_cout;
  assign acc_ovf = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rev_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rev_serial_adder : directed bench with transaction-level model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rev_serial_adder;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          cin, acc_mode, acc_clr;
  logic          out_valid, out_ready;
  logic [W-1:0]  sum;
  logic          cout, acc_ovf;

  always #5 clk = ~clk;

  rev_serial_adder #(.W(W), .D(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .acc_ovf   (acc_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: idle / busy for N edges / done until consumed.
  int          m_phase;
  int          m_k;
  logic [15:0] m_acc, m_sum, m_bop;
  logic [16:0] m_t;
  logic        m_cout, m_ovf, m_accop;
  logic        chk_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_acc = '0; m_sum = '0;
      m_cout = 1'b0; m_ovf = 1'b0; m_accop = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (acc_clr) begin m_acc = '0; m_ovf = 1'b0; end
          if (in_valid) begin
            m_bop   = acc_mode ? m_acc : b;
            m_t     = {1'b0, a} + {1'b0, m_bop} + 17'(cin);
            m_sum   = m_t[15:0];
            m_cout  = m_t[16];
            m_accop = acc_mode;
            m_k     = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_k++;
          if (m_k == N) begin
            m_phase = 2;
            if (m_accop) begin m_acc = m_sum; m_ovf = m_ovf | m_cout; end
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", in_ready, m_phase == 0);
      check("m_out_valid", out_valid, m_phase == 2);
      check("m_excl", in_ready & out_valid, 0);
      check("m_acc_ovf", acc_ovf, m_ovf);
      if (m_phase == 2 && rst_n) begin
        check("m_sum", sum, m_sum);
        check("m_cout", cout, m_cout);
      end
      if (!rst_n) begin
        check("m_rst_sum", sum, 0);
        check("m_rst_cout", cout, 0);
      end
    end
  end

  task automatic do_op(input logic [15:0] a_i, input logic [15:0] b_i, input logic cin_i,
                       input logic accm, input logic clr, input logic [15:0] exp_s,
                       input logic exp_c, input bit consume);
    int lat;
    @(negedge clk);
    check("in_ready_pre", in_ready, 1);
    a = a_i; b = b_i; cin = cin_i; acc_mode = accm; acc_clr = clr; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0; acc_mode = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N);
    check("sum", sum, exp_s);
    check("cout", cout, exp_c);
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_post", in_ready, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 0);
    check("rst_acc_ovf", acc_ovf, 0);
    rst_n = 1'b1;

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0100, 1'b0, 1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 1'b0, 1);

    // Backpressure: hold the result for three cycles while in_valid toggles.
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 0);
    a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      @(negedge clk);
      check("bp_sum", sum, 16'h0003);
      check("bp_cout", cout, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Accumulate: b is junk and must be ignored.
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    do_op(16'h8000, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 1);
    check("acc_ovf_first", acc_ovf, 0);
    do_op(16'h8000, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
    check("acc_ovf_set", acc_ovf, 1);
    do_op(16'h0005, 16'h1111, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 1);
    check("acc_ovf_cleared", acc_ovf, 0);

    // Reset after digit 2 of an accumulate op aborts it and clears acc.
    @(negedge clk);
    a = 16'h0777; b = 16'h0000; acc_mode = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; acc_mode = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 16'h0000);
    check("abort_acc_ovf", acc_ovf, 0);
    #2 rst_n = 1'b1;
    do_op(16'h0003, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
